vend_dispense_ctrl: RTL
=======================

Name: vend_dispense_ctrl

Overview:
- Sequences the per-item dispense motors and tracks stock for the four-slot vending machine.
- Accepts a one-cycle vend request (driven from the FSM's product-release pulse plus item code) and runs the motor for a fixed time, then waits for the drop sensor.
- Maintains per-item stock counts and jam flags, and drives the item0..item3 availability inputs of the vending FSM.
- Provides an operator refill port.

Parameters:
- STOCK_W, 4, width of each stock counter.
- MAX_STOCK, 15, saturation ceiling for refills; must be < 2**STOCK_W.
- INIT_STOCK, 4, value of every counter after reset.
- MOTOR_CYCLES, 8, clock cycles motor_en stays asserted per vend.
- DROP_TIMEOUT, 32, cycles to wait for drop_det before declaring a jam.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- vend_req  in  1  one-cycle request to dispense vend_item.
- vend_item  in  2  item index 0..3.
- drop_det  in  1  drop sensor, high for at least 1 cycle when an item falls.
- refill_req  in  1  one-cycle refill request.
- refill_item  in  2  item index to refill.
- refill_qty  in  STOCK_W  units added.
- motor_en  out  4  one-hot motor drive.
- vend_busy  out  1  high in any state other than IDLE.
- vend_done  out  1  one-cycle pulse on successful dispense.
- vend_fail  out  1  one-cycle pulse on rejected or jammed vend.
- refill_ack  out  1  one-cycle pulse when a refill is applied.
- item0_available, item1_available, item2_available, item3_available  out  1 each  high when stock[i]!=0 and jam[i]==0.
- low_stock  out  4  low-stock flags (see Optional Feature).

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all stock[i]=INIT_STOCK; all jam[i]=0; timers=0.
  - motor_en=0, vend_busy=0, vend_done=0, vend_fail=0, refill_ack=0.
  - availability outputs are 1, since INIT_STOCK>0.
  - Reset mid-dispense drops motor_en the same instant; no count change is retained.
- itemN_available: combinational from the stock and jam registers.
- All other outputs are registered.
- States: IDLE, CHECK, MOTOR, WAIT_DROP, DONE, JAM.
- IDLE:
  - vend_req=1: latch vend_item into sel, go to CHECK.
  - Else if refill_req=1: stock[refill_item]=min(stock+refill_qty, MAX_STOCK), computed at STOCK_W+1 bits before saturation; jam[refill_item] cleared; refill_ack=1 next cycle; stay in IDLE.
  - vend_req and refill_req together: vend wins; the refill is dropped with no ack.
  - refill_req outside IDLE is ignored (no ack).
- CHECK (1 cycle):
  - stock[sel]==0 or jam[sel]==1: vend_fail pulses the next cycle; go to IDLE.
  - Otherwise go to MOTOR with the motor timer loaded to MOTOR_CYCLES.
- MOTOR:
  - motor_en = one-hot(sel) for exactly MOTOR_CYCLES consecutive cycles, then go to WAIT_DROP.
  - drop_det during MOTOR is also accepted and remembered; the motor still completes its run, then goes directly to DONE.
- WAIT_DROP:
  - motor_en=0; the timeout counter counts from 0.
  - drop_det=1: go to DONE.
  - Counter reaches DROP_TIMEOUT-1 without drop_det: go to JAM.
  - drop_det on that same final cycle counts as success.
- DONE (1 cycle): stock[sel] decrements by 1 (never below 0); vend_done=1; go to IDLE.
- JAM (1 cycle): jam[sel]=1; vend_fail=1; stock is unchanged; go to IDLE.
- vend_req while vend_busy=1 is ignored, with no queueing.
- Latency from vend_req to vend_done with immediate drop: 1 (CHECK) + MOTOR_CYCLES + 1 (WAIT_DROP) + 1 cycles = 11 at defaults.
- Other latencies:
  - Rejection: vend_fail 2 cycles after vend_req.
  - Jam: vend_fail 2+MOTOR_CYCLES+DROP_TIMEOUT cycles after vend_req.
- motor_en is never multi-hot.

Optional Feature:
- Macro: VEND_LOW_STOCK_EN.
- Defined: low_stock[i] is registered high when stock[i] <= 2, and updates the cycle after any count change.
- Undefined: low_stock is tied to 4'b0000 and the compare logic is omitted.

Test Plan:
- Reset, then vend_req with item=2 and drop_det asserted 1 cycle after motor stops:
  - motor_en=4'b0100 for 8 cycles.
  - vend_done pulses at cycle 11.
  - stock[2]=3; item2_available stays 1.
- Four successful vends of item 0:
  - stock[0] reaches 0 and item0_available=0.
  - A fifth vend_req gives vend_fail 2 cycles later, with no motor_en.
- vend_req item=1 with no drop_det:
  - vend_fail at cycle 42; jam[1]=1; item1_available=0; stock[1]=4.
  - Refill item 1 with qty 0 clears the jam, gives refill_ack, and item1_available returns to 1.
- Refill item 3 with qty 14 from stock 4 saturates at 15.
- Same-cycle vend_req(item 0) and refill_req(item 0): vend proceeds, no refill_ack, stock[0] ends at 3.
- Assert rst mid-MOTOR:
  - motor_en goes to 0 immediately and stock returns to 4.
  - With VEND_LOW_STOCK_EN defined, two vends of item 2 set low_stock[2]=1 (stock=2); without the macro low_stock stays 0.

Source files
------------

// File: rtl/vend_dispense_if.sv
// Vend/refill handshake bundle between the vending FSM / operator panel
// (master) and the dispense controller (slave).
interface vend_dispense_if #(
  parameter int STOCK_W = 4
);
  logic               vend_req;
  logic [1:0]         vend_item;
  logic               drop_det;
  logic               refill_req;
  logic [1:0]         refill_item;
  logic [STOCK_W-1:0] refill_qty;
  logic [3:0]         motor_en;
  logic               vend_busy;
  logic               vend_done;
  logic               vend_fail;
  logic               refill_ack;
  logic               item0_available;
  logic               item1_available;
  logic               item2_available;
  logic               item3_available;
  logic [3:0]         low_stock;

  modport master (
    output vend_req, vend_item, drop_det, refill_req, refill_item, refill_qty,
    input  motor_en, vend_busy, vend_done, vend_fail, refill_ack,
           item0_available, item1_available, item2_available, item3_available,
           low_stock
  );

  modport slave (
    input  vend_req, vend_item, drop_det, refill_req, refill_item, refill_qty,
    output motor_en, vend_busy, vend_done, vend_fail, refill_ack,
           item0_available, item1_available, item2_available, item3_available,
           low_stock
  );
endinterface

// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer and stock tracker for a four-slot vending machine.
// Runs the selected motor for MOTOR_CYCLES, waits up to DROP_TIMEOUT cycles
// for the drop sensor, keeps per-slot stock counts and jam flags, and
// accepts operator refills while idle.
// Optional feature: define VEND_LOW_STOCK_EN to enable the registered
// low_stock flags (stock <= 2); otherwise low_stock is tied to zero.
module vend_dispense_ctrl #(
  parameter int STOCK_W      = 4,
  parameter int MAX_STOCK    = 15,
  parameter int INIT_STOCK   = 4,
  parameter int MOTOR_CYCLES = 8,
  parameter int DROP_TIMEOUT = 32
) (
  input logic           clk,
  input logic           rst,
  vend_dispense_if.slave bus
);

  localparam int MOTOR_W = $clog2(MOTOR_CYCLES + 1);
  localparam int WAIT_W  = $clog2(DROP_TIMEOUT + 1);
  localparam logic [STOCK_W:0]   MAX_EXT  = (STOCK_W + 1)'(MAX_STOCK);
  localparam logic [STOCK_W-1:0] INIT_VAL = STOCK_W'(INIT_STOCK);
  localparam logic [MOTOR_W-1:0] MOTOR_LOAD = MOTOR_W'(MOTOR_CYCLES);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(DROP_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, CHECK, MOTOR, WAIT_DROP, DONE, JAM} state_t;

  state_t             state_reg, state_next;
  logic [1:0]         sel_reg;
  logic [MOTOR_W-1:0] motor_cnt_reg;
  logic [WAIT_W-1:0]  wait_cnt_reg;
  logic               drop_seen_reg;
  logic [STOCK_W-1:0] stock_reg [4];
  logic [3:0]         jam_reg;

  logic [3:0] motor_en_reg, motor_en_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;
  logic       fail_reg, fail_next;
  logic       ack_reg, ack_next;

  logic               reject;
  logic               refill_hit;
  logic [STOCK_W:0]   refill_sum;
  logic [STOCK_W-1:0] refill_val;
  logic [3:0]         avail;

  // Slot is unusable when empty or flagged jammed.
  assign reject = (stock_reg[sel_reg] == '0) || jam_reg[sel_reg];

  // Refills only apply in IDLE and lose to a simultaneous vend request.
  assign refill_hit = (state_reg == IDLE) && !bus.vend_req && bus.refill_req;

  // Add at one extra bit so an overflowing sum still saturates correctly.
  assign refill_sum = {1'b0, stock_reg[bus.refill_item]} + {1'b0, bus.refill_qty};
  assign refill_val = (refill_sum > MAX_EXT) ? MAX_EXT[STOCK_W-1:0]
                                             : refill_sum[STOCK_W-1:0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (bus.vend_req) state_next = CHECK;
      CHECK:     state_next = reject ? IDLE : MOTOR;
      MOTOR: begin
        if (motor_cnt_reg == MOTOR_W'(1))
          state_next = (drop_seen_reg || bus.drop_det) ? DONE : WAIT_DROP;
      end
      WAIT_DROP: begin
        if (bus.drop_det)                    state_next = DONE;
        else if (wait_cnt_reg == WAIT_LAST)  state_next = JAM;
      end
      DONE:      state_next = IDLE;
      JAM:       state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Output decode, looking one state ahead so the outputs can be registered.
  always_comb begin
    motor_en_next = '0;
    if (state_next == MOTOR) motor_en_next = 4'b0001 << sel_reg;
    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
    fail_next = (state_next == JAM) || ((state_reg == CHECK) && reject);
    ack_next  = refill_hit;
  end

  // Registered outputs; async reset drops the motor immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      motor_en_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      fail_reg     <= 1'b0;
      ack_reg      <= 1'b0;
    end else begin
      motor_en_reg <= motor_en_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      fail_reg     <= fail_next;
      ack_reg      <= ack_next;
    end
  end

  // Selected slot, motor run timer, drop timeout counter and early-drop memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_reg       <= '0;
      motor_cnt_reg <= '0;
      wait_cnt_reg  <= '0;
      drop_seen_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE && bus.vend_req) sel_reg <= bus.vend_item;

      if (state_reg == CHECK)      motor_cnt_reg <= MOTOR_LOAD;
      else if (state_reg == MOTOR) motor_cnt_reg <= motor_cnt_reg - MOTOR_W'(1);

      if (state_reg == WAIT_DROP) wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
      else                        wait_cnt_reg <= '0;

      if (state_reg == CHECK)                      drop_seen_reg <= 1'b0;
      else if (state_reg == MOTOR && bus.drop_det) drop_seen_reg <= 1'b1;
    end
  end

  // Stock counts and jam flags: refill sets/clears, DONE decrements, JAM flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) stock_reg[i] <= INIT_VAL;
      jam_reg <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (refill_hit && bus.refill_item == 2'(i)) begin
          stock_reg[i] <= refill_val;
          jam_reg[i]   <= 1'b0;
        end else if (state_reg == DONE && sel_reg == 2'(i)) begin
          if (stock_reg[i] != '0) stock_reg[i] <= stock_reg[i] - STOCK_W'(1);
        end else if (state_reg == JAM && sel_reg == 2'(i)) begin
          jam_reg[i] <= 1'b1;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_avail
      assign avail[gi] = (stock_reg[gi] != '0) && !jam_reg[gi];
    end
  endgenerate

`ifdef VEND_LOW_STOCK_EN
  localparam logic INIT_LOW = (INIT_STOCK <= 2);
  logic [3:0] low_stock_reg;

  // Low-stock flags trail the stock counters by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      low_stock_reg <= {4{INIT_LOW}};
    end else begin
      for (int i = 0; i < 4; i++) low_stock_reg[i] <= (stock_reg[i] <= STOCK_W'(2));
    end
  end

  assign bus.low_stock = low_stock_reg;
`else
  assign bus.low_stock = 4'b0000;
`endif

  assign bus.motor_en        = motor_en_reg;
  assign bus.vend_busy       = busy_reg;
  assign bus.vend_done       = done_reg;
  assign bus.vend_fail       = fail_reg;
  assign bus.refill_ack      = ack_reg;
  assign bus.item0_available = avail[0];
  assign bus.item1_available = avail[1];
  assign bus.item2_available = avail[2];
  assign bus.item3_available = avail[3];

endmodule
